// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory controller: FSM encoding and address width.
package imem_pkg;

    localparam int ADDR_W = 32;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/imem_word_asm.sv
// Byte-to-word assembler: packs loader bytes little-endian into a 4-lane word and
// flags word_done on the fourth byte or on a last byte (remaining lanes read as zero).
module imem_word_asm
    import imem_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [WIDTH-1:0]   byte_data,
    input  logic               byte_last,
    output logic               word_done,
    output logic [4*WIDTH-1:0] word
);

    logic [1:0] byte_cnt_reg;

    assign word_done = byte_valid && ((byte_cnt_reg == 2'd3) || byte_last);

    always_ff @(posedge clk) begin
        if (rst || clear || word_done) begin
            byte_cnt_reg <= 2'd0;
        end else if (byte_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

    // Lanes are cleared after every word, so lanes above the last byte read as zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [WIDTH-1:0] lane_reg;
            logic             hit;

            assign hit = byte_valid && (byte_cnt_reg == 2'(gi));

            always_ff @(posedge clk) begin
                if (rst || clear || word_done) begin
                    lane_reg <= '0;
                end else if (hit) begin
                    lane_reg <= byte_data;
                end
            end

            assign word[gi*WIDTH +: WIDTH] = hit ? byte_data : lane_reg;
        end
    endgenerate

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: LOAD fills memory from a byte loader, RUN serves fetches.
// Optional macro IMEM_ALIGN_CHECK_EN adds the fetch_err output for misaligned/out-of-range fetches.
module inst_mem_ctrl
    import imem_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_last,
    output logic              load_ready,
    input  logic              reload,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [31:0]       fetch_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              running,
    output logic              load_ovf
`ifdef IMEM_ALIGN_CHECK_EN
    ,
    output logic              fetch_err
`endif
);

    logic [0:0]        state_reg;
    logic [ADDR_W-1:0] load_addr_reg;
    logic              load_ovf_reg;
    logic              last_pend_reg;
    logic              mem_we_reg;
    logic [31:0]       mem_wdata_reg;
    logic              fetch_valid_reg;
    logic [31:0]       fetch_data_reg;

    logic              in_load;
    logic              in_run;
    logic              byte_acc;
    logic              fetch_acc;
    logic              word_done;
    logic [4*WIDTH-1:0] asm_word;
    logic              addr_wrap;
    logic [31:0]       fetch_word;

    assign in_load = (state_reg == LOAD);
    assign in_run  = (state_reg == RUN);

    // No bytes are taken while the final word is being written out.
    assign load_ready  = in_load && !reload && !last_pend_reg;
    assign byte_acc    = load_ready && load_valid;
    assign fetch_ready = in_run && !reload;
    assign fetch_acc   = fetch_ready && fetch_req;
    assign addr_wrap   = (load_addr_reg == ADDR_W'(DEPTH - 4));

    imem_word_asm #(
        .WIDTH(WIDTH)
    ) u_word_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (reload),
        .byte_valid (byte_acc),
        .byte_data  (load_data),
        .byte_last  (load_last),
        .word_done  (word_done),
        .word       (asm_word)
    );

`ifdef IMEM_ALIGN_CHECK_EN
    logic fetch_bad;
    logic fetch_err_reg;

    assign fetch_bad  = (fetch_addr[1:0] != 2'b00) || (fetch_addr > ADDR_W'(DEPTH - 4));
    assign fetch_word = fetch_bad ? 32'd0 : mem_rdata;
    assign fetch_err  = fetch_err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_err_reg <= 1'b0;
        end else begin
            fetch_err_reg <= fetch_acc && fetch_bad;
        end
    end
`else
    assign fetch_word = mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= LOAD;
            load_addr_reg   <= '0;
            load_ovf_reg    <= 1'b0;
            last_pend_reg   <= 1'b0;
            mem_we_reg      <= 1'b0;
            mem_wdata_reg   <= 32'd0;
            fetch_valid_reg <= 1'b0;
            fetch_data_reg  <= 32'd0;
        end else begin
            mem_we_reg      <= word_done;
            last_pend_reg   <= word_done && load_last;
            fetch_valid_reg <= fetch_acc;
            if (word_done) begin
                mem_wdata_reg <= 32'(asm_word);
            end
            if (fetch_acc) begin
                fetch_data_reg <= fetch_word;
            end

            if (reload) begin
                state_reg     <= LOAD;
                load_addr_reg <= '0;
                load_ovf_reg  <= 1'b0;
                last_pend_reg <= 1'b0;
            end else begin
                if (last_pend_reg) begin
                    state_reg <= RUN;
                end
                // Address advances once the word on the bus has been written.
                if (mem_we_reg) begin
                    if (addr_wrap) begin
                        load_addr_reg <= '0;
                        load_ovf_reg  <= 1'b1;
                    end else begin
                        load_addr_reg <= load_addr_reg + ADDR_W'(4);
                    end
                end
            end
        end
    end

    assign mem_we      = mem_we_reg;
    assign mem_wdata   = mem_wdata_reg;
    assign mem_addr    = in_run ? fetch_addr : load_addr_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_data  = fetch_data_reg;
    assign running     = in_run;
    assign load_ovf    = load_ovf_reg;

endmodule

// File: doc/inst_mem_ctrl.md
INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: memory byte-lane width in bits.
REQ-002 Parameter DEPTH, default 32: memory size in bytes; a multiple of 4.
REQ-003 Port clk  input  1: sole clock; all logic on posedge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port load_valid  input  1: loader byte available.
REQ-006 Port load_data  input  WIDTH: loader byte, little-endian order within each word.
REQ-007 Port load_last  input  1: qualifies the final byte of the program.
REQ-008 Port load_ready  output  1: controller accepts a loader byte this cycle.
REQ-009 Port reload  input  1: return to LOAD and restart at address 0.
REQ-010 Port fetch_req  input  1: fetch request.
REQ-011 Port fetch_addr  input  32: fetch byte address.
REQ-012 Port fetch_ready  output  1: fetch request accepted this cycle.
REQ-013 Port fetch_valid  output  1: fetch_data valid, one-cycle pulse.
REQ-014 Port fetch_data  output  32: fetched instruction word.
REQ-015 Port mem_we  output  1: memory word write strobe.
REQ-016 Port mem_addr  output  32: memory byte address.
REQ-017 Port mem_wdata  output  32: memory write word.
REQ-018 Port mem_rdata  input  32: memory combinational read word.
REQ-019 Port running  output  1: high in RUN state.
REQ-020 Port load_ovf  output  1: sticky flag, load wrapped past DEPTH.

Function
REQ-021 FSM states: LOAD and RUN; reset enters LOAD.
REQ-022 LOAD: load_ready=1 and fetch_ready=0; each accepted byte goes to lane byte_cnt of a 32-bit assembly register; byte_cnt increments modulo 4.
REQ-023 Fourth byte accepted: mem_we=1 for exactly one cycle on the next cycle with mem_addr=load_addr and the assembled word; load_addr then increments by 4.
REQ-024 load_addr wrap: at DEPTH-4 the next value is 0 and load_ovf sets; load_ovf clears only on rst or reload.
REQ-025 load_last accepted with byte_cnt<3: unfilled lanes are zero; the partial word is written the same way as a full word.
REQ-026 Final write issued: the FSM enters RUN on the following cycle; byte_cnt and the assembly register clear.
REQ-027 RUN: load_ready=0, fetch_ready=1, and loader inputs are ignored.
REQ-028 RUN with fetch_req=1: mem_addr=fetch_addr combinationally.
REQ-029 Fetch latency: on the next cycle fetch_valid=1 and fetch_data holds mem_rdata registered at acceptance.
REQ-030 Fetch throughput: one fetch per cycle; back-to-back requests are allowed.
REQ-031 In RUN, mem_we is always 0.
REQ-032 reload in RUN: the FSM enters LOAD next cycle; load_addr=0, byte_cnt=0, load_ovf=0, and fetch_ready drops that same cycle.
REQ-033 A fetch accepted in the cycle before reload still delivers fetch_valid.
REQ-034 reload in LOAD restarts loading: load_addr=0, byte_cnt=0, and any partial word is discarded without a write.
REQ-035 reload has priority over a simultaneous load_valid; the coincident byte is not accepted.

Reset
REQ-036 Reset values: state=LOAD, load_addr=0, byte_cnt=0, load_ovf=0, fetch_valid=0, fetch_data=0, mem_we=0, mem_wdata=0, running=0.
REQ-037 rst mid-load drops any partial word with no write; rst overrides reload and all handshakes.

Configuration
REQ-038 Macro IMEM_ALIGN_CHECK_EN defined: fetch_addr[1:0]!=0 or fetch_addr>DEPTH-4 drives output fetch_err=1, aligned with fetch_valid, and fetch_data=0.
REQ-039 Macro IMEM_ALIGN_CHECK_EN undefined: the fetch_err port does not exist, and the address passes unchecked.

Structure
REQ-040 Shared package imem_pkg holds the FSM state encoding (LOAD=0, RUN=1) and the constant ADDR_W=32.
REQ-041 One sub-module, imem_word_asm, holds the byte-to-word assembler (byte_cnt, lanes, zero-pad, word_done); the FSM and fetch path stay in inst_mem_ctrl.

Verification
REQ-042 Scenario, full word load: reset, bytes 0x13,0x00,0x00,0x00 -> one mem_we at addr 0 with wdata 0x00000013.
REQ-043 Scenario, partial last word: 6 bytes 0x01..0x06 with load_last on byte 6 -> writes 0x04030201@0 and 0x00000605@4, then running=1.
REQ-044 Scenario, back-to-back fetches: in RUN, fetch_req on addr 0 then 4 in consecutive cycles -> fetch_valid both following cycles with matching mem_rdata.
REQ-045 Scenario, overflow wrap: 36 bytes, DEPTH=32 -> ninth write at addr 0 and load_ovf=1.
REQ-046 Scenario, reload with fetch in flight: fetch accepted, reload next cycle -> fetch_valid delivered, then LOAD with load_ready=1 and load_ovf=0.
REQ-047 Scenario, alignment check: with IMEM_ALIGN_CHECK_EN, fetch_addr=0x2 -> fetch_err=1 and fetch_data=0.
